pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter. It is the successor to the fixed 8-bit, right-shift-only combinational shifter. It adds configurable width, four shift modes, one register stage per shift level, and a valid/ready handshake on input and output. It sits between datapath producers and consumers (ALU, normaliser) that need sustained one-result-per-cycle throughput.

Parameters:
WIDTH, 8, data width in bits; must be a power of two, 2 to 64
SHW, log2(WIDTH) (derived, localparam), shift-amount width and pipeline depth

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  WIDTH  operand
in_shamt  input  SHW  shift amount, 0 to WIDTH-1
in_mode  input  2  shift mode: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_data  output  WIDTH  shifted result
out_mode  output  2  mode of the beat on out_data, passed through for downstream tagging

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Pipeline has SHW stages. Stage s (s = 0..SHW-1) conditionally shifts by 2^(SHW-1-s), MSB weight first (e.g. 4, 2, 1 for WIDTH=8).
- Each stage registers: valid, data, mode, and the remaining shamt bits.
- Stage s applies its shift iff its shamt bit (SHW-1-s) is 1. Fill rules:
  - Logical right: zeros enter at the MSB end.
  - Arithmetic right: the original operand MSB (sign) enters. Sign is taken from the stage's data MSB, which is invariant under sign-filled shifts.
  - Logical left: zeros enter at the LSB end.
  - Rotate right: bits leaving the LSB end re-enter at the MSB end.
- Global advance enable: adv = out_ready | ~out_valid.
- in_ready = adv, combinational from out_ready and the out_valid register. There is no combinational path from in_valid.
- When adv=1, every stage loads from its predecessor. Stage 0 loads {in_valid, in_data, in_mode, in_shamt}. Bubbles (valid=0) propagate as-is.
- When adv=0, all stages hold their contents. out_data and out_mode stay stable while out_valid=1 and out_ready=0.
- A beat is accepted iff in_valid & in_ready. A beat is delivered iff out_valid & out_ready.
- Latency: exactly SHW cycles from acceptance to out_valid=1 when there is no stall. Each stall cycle adds one cycle.
- Throughput: one beat per cycle when out_ready is held 1. No bubbles are inserted.
- Data registers of invalid stages may hold anything. out_data is only meaningful while out_valid=1.
- Ordering: beats leave in acceptance order. No beat is ever dropped or duplicated.
- shamt=0: result equals in_data for all modes.
- shamt=WIDTH-1 arithmetic right: result is all copies of the sign bit.
- Reset values: all stage valid bits 0, out_valid=0, out_data=0, out_mode=0. in_ready=1 on the first cycle after reset.
- rst asserted mid-operation discards all in-flight beats. The next cycle shows out_valid=0, with no partial or stale output afterwards.
- rst has priority over adv and in_valid in the same cycle. A beat presented while rst=1 is not accepted.
- Outputs out_valid, out_data and out_mode are registered. There is no combinational input-to-output path.

Test Plan:
- WIDTH=8, in_data=0xB4, in_shamt=3, out_ready=1; one beat per mode 00/01/10/11 on consecutive cycles -> out_data 0x16, 0xF6, 0xA0, 0x96 on 4 consecutive cycles, first at 3 cycles after acceptance, out_mode 0,1,2,3.
- Exhaustive sweep: WIDTH=8, all 256 data × 8 shamt × 4 modes, back-to-back, out_ready=1 -> every result matches the reference model, in order, with no gaps; repeat with WIDTH=32 and random data.
- Backpressure: stream 10 beats and hold out_ready=0 for 5 cycles while out_valid=1 -> out_data/out_mode stable, in_ready=0, no beat lost or duplicated after release.
- Random in_valid (50%) and random out_ready (50%), 10k beats -> scoreboard matches exactly, order preserved.
- Boundaries: in_data=0x80 with shamt=7 in modes 01 and 11 -> 0xFF and 0x01; shamt=0 in any mode -> passthrough.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle -> out_valid=0 and in_ready=1 the following cycle, and none of the 3 beats ever appear.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter with a valid/ready handshake on both sides.
// One register stage per shift level, largest shift first, so a beat needs
// exactly SHW cycles to cross the pipe when the output is not stalled.
// A single advance enable moves every stage at once; when the consumer stalls
// with a result waiting, the whole pipe holds and the input is refused.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam logic [1:0] MODE_LSR = 2'b00;  // logical right, zero fill
  localparam logic [1:0] MODE_ASR = 2'b01;  // arithmetic right, sign fill
  localparam logic [1:0] MODE_LSL = 2'b10;  // logical left, zero fill
  localparam logic [1:0] MODE_ROR = 2'b11;  // rotate right

  // Pipe advances whenever the output slot is empty or being drained.
  // Depends only on out_ready and a register, never on in_valid.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
    // Shift weight of this level: MSB weight first (e.g. 4, 2, 1 for WIDTH=8).
    localparam int AMT = 1 << (SHW - 1 - gi);
    // Number of shift-amount bits still unconsumed when a beat enters here.
    localparam int RW  = SHW - gi;

    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic [1:0]       m_in;
    logic [RW-1:0]    s_in;

    logic [WIDTH-1:0] data_d;

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       mode_q;

    // Stage 0 takes the input port; later stages take their predecessor.
    if (gi == 0) begin : g_src
      assign v_in = in_valid;
      assign d_in = in_data;
      assign m_in = in_mode;
      assign s_in = in_shamt;
    end else begin : g_src
      assign v_in = g_stage[gi-1].valid_q;
      assign d_in = g_stage[gi-1].data_q;
      assign m_in = g_stage[gi-1].mode_q;
      assign s_in = g_stage[gi-1].g_rem.rem_q;
    end

    // Conditionally shift by this level's weight; the top remaining bit decides.
    // Arithmetic shifts read the sign from the current data MSB, which earlier
    // sign-filled shifts leave unchanged.
    always_comb begin
      data_d = d_in;
      if (s_in[RW-1]) begin
        case (m_in)
          MODE_LSR: data_d = d_in >> AMT;
          MODE_ASR: data_d = $signed(d_in) >>> AMT;
          MODE_LSL: data_d = d_in << AMT;
          MODE_ROR: data_d = (d_in >> AMT) | (d_in << (WIDTH - AMT));
          default:  data_d = d_in;
        endcase
      end
    end

    // Stage register: loads from the predecessor on advance, holds otherwise.
    // Bubbles travel through unchanged; reset clears everything.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        mode_q  <= '0;
      end else if (adv) begin
        valid_q <= v_in;
        data_q  <= data_d;
        mode_q  <= m_in;
      end
    end

    // The last stage has no shift bits left to pass on.
    if (gi < SHW - 1) begin : g_rem
      logic [RW-2:0] rem_q;

      // Carry the lower, not yet consumed shift-amount bits to the next level.
      always_ff @(posedge clk) begin
        if (rst) begin
          rem_q <= '0;
        end else if (adv) begin
          rem_q <= s_in[RW-2:0];
        end
      end
    end
  end

  // The final stage register is the output register.
  assign out_valid = g_stage[SHW-1].valid_q;
  assign out_data  = g_stage[SHW-1].data_q;
  assign out_mode  = g_stage[SHW-1].mode_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomized bench for the pipelined barrel shifter.
// Two instances: WIDTH=8 (main checks) and WIDTH=32 (random-data sweep).
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ov8, or8;
  logic [7:0] id8, od8;
  logic [2:0] is8;
  logic [1:0] im8, om8;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] id32, od32;
  logic [4:0]  is32;
  logic [1:0]  im32, om32;

  pipelined_barrel_shifter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_shamt(is8), .in_mode(im8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_mode(om8)
  );

  pipelined_barrel_shifter #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_shamt(is32), .in_mode(im32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_mode(om32)
  );

  typedef struct {
    longint unsigned data;
    int              mode;
    int              cyc_n;
  } beat_t;

  beat_t exp8[$], rcv8[$], exp32[$], rcv32[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: shift results from plain arithmetic on the operand value.
  function automatic longint unsigned model(input int w, input longint unsigned d,
                                            input int sh, input int mode);
    longint unsigned modv, res;
    longint sv, pl, q;
    modv = 64'd1 << w;
    pl   = longint'(64'd1 << sh);
    res  = 0;
    case (mode)
      0: res = d / longint'(pl);
      1: begin
        sv  = (d >= modv / 2) ? longint'(d) - longint'(modv) : longint'(d);
        q   = (sv >= 0) ? sv / pl : -((-sv + pl - 1) / pl);
        res = $unsigned(q) & (modv - 1);
      end
      2: res = (d * longint'(pl)) % modv;
      default: begin
        for (int i = 0; i < w; i++)
          if (d[(i + sh) % w]) res = res | (64'd1 << i);
      end
    endcase
    return res;
  endfunction

  // Record every delivered beat with the index of the edge that delivers it.
  beat_t mb8, mb32;
  always @(negedge clk) begin
    if (!rst && ov8 && or8) begin
      mb8.data = od8; mb8.mode = om8; mb8.cyc_n = cyc + 1;
      rcv8.push_back(mb8);
    end
    if (!rst && ov32 && or32) begin
      mb32.data = od32; mb32.mode = om32; mb32.cyc_n = cyc + 1;
      rcv32.push_back(mb32);
    end
  end

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then return 1ns after the edge.
  task automatic tick(output bit a8, output bit a32);
    @(negedge clk);
    a8  = iv8 && ir8 && !rst;
    a32 = iv32 && ir32 && !rst;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    bit a8, a32;
    iv8 = 1'b0; iv32 = 1'b0;
    repeat (n) tick(a8, a32);
  endtask

  task automatic send8(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
    bit a8, a32;
    int k;
    beat_t b;
    k = 0;
    iv8 = 1'b1; id8 = d; is8 = s; im8 = m;
    do begin tick(a8, a32); k++; end while (!a8 && k < 1000);
    if (a8) begin
      b.data = model(8, d, s, m); b.mode = m; b.cyc_n = cyc;
      exp8.push_back(b);
    end else begin
      check("send8_timeout", 0, 1);
    end
    iv8 = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
    bit a8, a32;
    int k;
    beat_t b;
    k = 0;
    iv32 = 1'b1; id32 = d; is32 = s; im32 = m;
    do begin tick(a8, a32); k++; end while (!a32 && k < 1000);
    if (a32) begin
      b.data = model(32, d, s, m); b.mode = m; b.cyc_n = cyc;
      exp32.push_back(b);
    end else begin
      check("send32_timeout", 0, 1);
    end
    iv32 = 1'b0;
  endtask

  // Compare a whole delivered stream against the expected one, then clear both.
  task automatic compare_stream(input bit wide, input string tag, input bit chk_lat);
    beat_t e[$], r[$];
    int n, lat;
    lat = wide ? 5 : 3;
    if (wide) begin
      e = exp32; r = rcv32; exp32.delete(); rcv32.delete();
    end else begin
      e = exp8; r = rcv8; exp8.delete(); rcv8.delete();
    end
    check({tag, "_count"}, r.size(), e.size());
    n = (r.size() < e.size()) ? r.size() : e.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), r[i].data, e[i].data);
      check($sformatf("%s_mode[%0d]", tag, i), r[i].mode, e[i].mode);
      if (chk_lat)
        check($sformatf("%s_lat[%0d]", tag, i), r[i].cyc_n - e[i].cyc_n, lat);
    end
  endtask

  initial begin
    bit a8, a32;
    int t0, got, k;
    logic [7:0] dir_exp [4];
    logic [7:0] pt_data [4];
    logic [7:0] snap_d;
    logic [1:0] snap_m;
    logic [7:0] pd;
    logic [2:0] ps;
    logic [1:0] pm;
    beat_t b;

    // Reset, with a beat presented during reset that must not be taken.
    rst = 1'b1;
    iv8 = 1'b1; id8 = 8'h5A; is8 = 3'd1; im8 = 2'd0; or8 = 1'b0;
    iv32 = 1'b0; id32 = '0; is32 = '0; im32 = '0; or32 = 1'b1;
    repeat (2) tick(a8, a32);
    rst = 1'b0; iv8 = 1'b0;
    check("rst_out_valid", ov8, 0);
    check("rst_out_data", od8, 0);
    check("rst_out_mode", om8, 0);
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid32", ov32, 0);
    or8 = 1'b1;
    drain(8);
    check("rst_no_accept", rcv8.size(), 0);

    // Directed: 0xB4 >> 3 in each mode, back to back.
    dir_exp[0] = 8'h16; dir_exp[1] = 8'hF6; dir_exp[2] = 8'hA0; dir_exp[3] = 8'h96;
    for (int m = 0; m < 4; m++) send8(8'hB4, 3'd3, 2'(m));
    drain(6);
    check("dir_count", rcv8.size(), 4);
    if (rcv8.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("dir_const[%0d]", i), rcv8[i].data, dir_exp[i]);
        check($sformatf("dir_outmode[%0d]", i), rcv8[i].mode, i);
        check($sformatf("dir_consec[%0d]", i), rcv8[i].cyc_n - rcv8[0].cyc_n, i);
      end
    end
    compare_stream(0, "dir", 1);

    // Boundaries: sign fill and rotate at shamt=7, passthrough at shamt=0.
    send8(8'h80, 3'd7, 2'd1);
    send8(8'h80, 3'd7, 2'd3);
    for (int m = 0; m < 4; m++) begin
      pt_data[m] = 8'($urandom_range(0, 255));
      send8(pt_data[m], 3'd0, 2'(m));
    end
    drain(6);
    check("bnd_count", rcv8.size(), 6);
    if (rcv8.size() >= 6) begin
      check("bnd_asr7", rcv8[0].data, 8'hFF);
      check("bnd_ror7", rcv8[1].data, 8'h01);
      for (int m = 0; m < 4; m++)
        check($sformatf("bnd_pass[%0d]", m), rcv8[2 + m].data, pt_data[m]);
    end
    compare_stream(0, "bnd", 1);

    // Exhaustive WIDTH=8 sweep, one beat per cycle.
    t0 = cyc;
    for (int d = 0; d < 256; d++)
      for (int s = 0; s < 8; s++)
        for (int m = 0; m < 4; m++)
          send8(8'(d), 3'(s), 2'(m));
    check("sweep_cycles", cyc - t0, 8192);
    drain(8);
    compare_stream(0, "sweep8", 1);

    // WIDTH=32 sweep of every shamt and mode with random data, twice.
    t0 = cyc;
    for (int rep = 0; rep < 2; rep++)
      for (int s = 0; s < 32; s++)
        for (int m = 0; m < 4; m++)
          send32($urandom, 5'(s), 2'(m));
    check("sweep32_cycles", cyc - t0, 256);
    drain(10);
    compare_stream(1, "sweep32", 1);

    // Backpressure: stall 5 cycles with a result waiting.
    for (int i = 0; i < 4; i++) send8(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'(i));
    or8 = 1'b0;
    check("bp_out_valid", ov8, 1);
    snap_d = od8; snap_m = om8;
    iv8 = 1'b1; id8 = 8'h3C; is8 = 3'd2; im8 = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick(a8, a32);
      check($sformatf("bp_accept[%0d]", i), a8, 0);
      check($sformatf("bp_in_ready[%0d]", i), ir8, 0);
      check($sformatf("bp_valid[%0d]", i), ov8, 1);
      check($sformatf("bp_data[%0d]", i), od8, snap_d);
      check($sformatf("bp_mode[%0d]", i), om8, snap_m);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    send8(8'h3C, 3'd2, 2'd1);
    for (int i = 0; i < 5; i++) send8(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    drain(8);
    compare_stream(0, "bp", 0);

    // Random valid and ready, 10k beats.
    got = 0; k = 0;
    pd = 8'($urandom_range(0, 255)); ps = 3'($urandom_range(0, 7)); pm = 2'($urandom_range(0, 3));
    while (got < 10000 && k < 60000) begin
      or8 = 1'($urandom_range(0, 1));
      iv8 = 1'($urandom_range(0, 1));
      id8 = pd; is8 = ps; im8 = pm;
      tick(a8, a32);
      k++;
      if (a8) begin
        b.data = model(8, pd, ps, pm); b.mode = pm; b.cyc_n = cyc;
        exp8.push_back(b);
        got++;
        pd = 8'($urandom_range(0, 255)); ps = 3'($urandom_range(0, 7)); pm = 2'($urandom_range(0, 3));
      end
    end
    check("rand_accepted", got, 10000);
    or8 = 1'b1;
    drain(10);
    compare_stream(0, "rand", 0);

    // Reset mid-flight: three beats in the pipe are discarded.
    or8 = 1'b0;
    for (int i = 0; i < 3; i++) send8(8'hC3 + 8'(i), 3'd1, 2'(i));
    exp8.delete();
    rst = 1'b1;
    tick(a8, a32);
    rst = 1'b0;
    check("rstmid_out_valid", ov8, 0);
    check("rstmid_in_ready", ir8, 1);
    check("rstmid_out_data", od8, 0);
    or8 = 1'b1;
    drain(8);
    check("rstmid_flushed", rcv8.size(), 0);
    send8(8'h81, 3'd4, 2'd3);
    drain(6);
    compare_stream(0, "post_rst", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
